sram_port_arb: RTL and testbench
================================

Name: sram_port_arb

Overview:
- Round-robin arbiter that shares one single-port SRAM macro port (cs/we/addr/byte/di/do/busy style) among NREQ simple requesters.
- Sits between requester-side memory engines (MMU walkers, L1 refill/write-back, DMA) and one sram bank instance, replacing per-bank ad-hoc muxing.
- Issues at most one access per cycle.
- Routes the 1-cycle-latency read data back to the requester that issued the read.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 32, address width on request and memory side
DW, 32, data width; byte-enable width BW = DW/8

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
req_vld  input  NREQ  per-requester access request, held until granted
req_we  input  NREQ  1 = write, 0 = read
req_addr  input  NREQ*AW  flattened addresses, requester i at [i*AW +: AW]
req_byte  input  NREQ*BW  flattened byte enables
req_wdata  input  NREQ*DW  flattened write data
req_gnt  output  NREQ  one-hot grant, same cycle as issue
rsp_vld  output  NREQ  one-hot read-data valid
rsp_rdata  output  DW  read data, shared by all requesters, qualified by rsp_vld
m_cs  output  1  SRAM chip select
m_we  output  1  SRAM write enable
m_addr  output  AW  SRAM address
m_byte  output  BW  SRAM byte enables
m_di  output  DW  SRAM write data
m_do  input  DW  SRAM read data, valid the cycle after a read cs
m_busy  input  1  SRAM not able to accept an access this cycle

Behaviour:
- Reset: synchronous, active-high, sampled on posedge clk.
  - rr_ptr=0, rsp_vld=0, rsp_rdata=0, owner register=0, read-pending flag=0.
  - While rst=1, req_gnt=0 and m_cs=0 combinationally.
- Arbitration is combinational in the issue cycle. The winner is the first i with req_vld[i]=1, searching rr_ptr, rr_ptr+1, ... NREQ-1, then wrapping to 0.
- When m_busy=0 and any req_vld=1:
  - req_gnt[winner]=1 and m_cs=1.
  - m_we, m_addr, m_byte, m_di are muxed from the winner.
- When m_busy=1 or no request:
  - req_gnt=0 and m_cs=0.
  - m_we=0, m_byte=0. m_addr and m_di hold the winner's values (don't-care).
- Handshake: a request completes on the cycle with req_vld[i] & req_gnt[i]. The requester keeps req_* stable until then and may change them the cycle after. There is no withdrawal rule; dropping req_vld before grant is legal.
- Pointer update on every grant: rr_ptr <= winner+1, wrapping from NREQ-1 to 0. No grant leaves rr_ptr unchanged.
- Read return, fixed latency 1:
  - Granting a read (we=0) registers owner=winner and rd_pend=1. rd_pend=0 if there was no read grant.
  - In the cycle after the grant, rsp_vld[owner]=1 and rsp_rdata=m_do. Both are driven combinationally from the registered owner/flag and m_do.
  - rsp_rdata holds 0 when rsp_vld=0.
- Writes produce no response. The grant is the completion.
- Back-to-back: a new grant may be issued in the same cycle a read returns. This sustains 1 access/cycle.
- Fairness: with all NREQ requesting continuously, each requester is granted exactly once per NREQ cycles.
- m_busy mid-stream: stalls issue only. A read already granted still returns on the next cycle regardless of m_busy.
- Reset mid-operation: a pending read response is dropped (rsp_vld=0 next cycle). Requesters re-issue after reset.

Optional Feature:
- SRAM_PORT_ARB_PERF_EN defined: adds outputs perf_gnt_cnt (NREQ*32) and perf_stall_cnt (32).
  - perf_gnt_cnt[i] increments on each grant to requester i.
  - perf_stall_cnt increments each cycle any req_vld=1 but no grant is issued (m_busy).
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: the ports and counters do not exist. Arbitration behaviour is identical.

Test Plan:
- Single read: req_vld=4'b0010, addr=32'h100, m_do=32'hDEADBEEF next cycle -> req_gnt=4'b0010 in cycle 0; rsp_vld=4'b0010 and rsp_rdata=32'hDEADBEEF in cycle 1.
- All four requesting continuously for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; m_cs=1 every cycle.
- Write then read: req0 write addr 32'h40, byte=4'hC, wdata=32'h12345678 -> m_we=1, m_byte=4'hC, no rsp_vld. Next cycle req1 reads 32'h40 -> rsp_vld[1] the following cycle.
- m_busy=1 for 3 cycles with req2 and req3 pending -> no grant and rr_ptr unchanged. After busy drops: req2 granted, then req3.
- Read granted in cycle N with m_busy=1 in cycle N+1 -> rsp_vld still asserted in N+1; no new grant in N+1.
- rst asserted the cycle after a read grant -> rsp_vld=0 and rr_ptr=0. With SRAM_PORT_ARB_PERF_EN, counters read 0.

Source files
------------

// File: rtl/sram_port_arb.sv
// rtl/sram_port_arb.sv - round-robin arbiter sharing one single-port SRAM port
//
// Shares one single-port SRAM macro port among NREQ requesters. At most one
// access is issued per cycle. The winner is picked combinationally, searching
// from rr_ptr upward with wrap-around. Read data (fixed 1-cycle latency) is
// routed back to the requester that issued the read.
//
// Optional build macro: SRAM_PORT_ARB_PERF_EN adds saturating grant and stall
// counters (perf_gnt_cnt, perf_stall_cnt).
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_vld/we     per-requester request valid and write flag
//   req_addr       flattened addresses, requester i at [i*AW +: AW]
//   req_byte       flattened byte enables, requester i at [i*BW +: BW]
//   req_wdata      flattened write data, requester i at [i*DW +: DW]
//   req_gnt        one-hot grant, asserted in the issue cycle
//   rsp_vld        one-hot read-data valid, cycle after a read grant
//   rsp_rdata      shared read data, zero when no response
//   m_cs/we/addr/byte/di  SRAM access outputs
//   m_do, m_busy   SRAM read data and stall input
//   perf_gnt_cnt   per-requester grant counters, 32 bits each (macro only)
//   perf_stall_cnt cycles with a request pending but m_busy (macro only)
module sram_port_arb #(
   parameter int NREQ = 4,
   parameter int AW   = 32,
   parameter int DW   = 32,
   localparam int BW  = DW / 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_vld,
   input  logic [NREQ-1:0]      req_we,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*BW-1:0]   req_byte,
   input  logic [NREQ*DW-1:0]   req_wdata,
   output logic [NREQ-1:0]      req_gnt,
   output logic [NREQ-1:0]      rsp_vld,
   output logic [DW-1:0]        rsp_rdata,
   output logic                 m_cs,
   output logic                 m_we,
   output logic [AW-1:0]        m_addr,
   output logic [BW-1:0]        m_byte,
   output logic [DW-1:0]        m_di,
   input  logic [DW-1:0]        m_do,
   input  logic                 m_busy
`ifdef SRAM_PORT_ARB_PERF_EN
   ,
   output logic [NREQ*32-1:0]   perf_gnt_cnt,
   output logic [31:0]          perf_stall_cnt
`endif
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] owner;
   logic          rd_pend;

   logic [PW-1:0] winner;
   logic [PW:0]   idx;
   logic          win_any;
   logic          win_we;
   logic [AW-1:0] win_addr;
   logic [BW-1:0] win_byte;
   logic [DW-1:0] win_wdata;
   logic          issue;
   logic          rsp_on;

   // Rotating priority search. idx is one bit wider than rr_ptr so the
   // rr_ptr+k sum can be folded back into 0..NREQ-1 with one subtraction.
   always_comb begin
      win_any = 1'b0;
      winner  = '0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, rr_ptr} + (PW+1)'(k);
         if (idx >= (PW+1)'(NREQ))
            idx = idx - (PW+1)'(NREQ);
         if (!win_any && req_vld[idx[PW-1:0]]) begin
            win_any = 1'b1;
            winner  = idx[PW-1:0];
         end
      end
   end

   always_comb begin
      win_we    = 1'b0;
      win_addr  = '0;
      win_byte  = '0;
      win_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (winner == PW'(i)) begin
            win_we    = req_we[i];
            win_addr  = req_addr[i*AW +: AW];
            win_byte  = req_byte[i*BW +: BW];
            win_wdata = req_wdata[i*DW +: DW];
         end
      end
   end

   // Reset gates issue combinationally so nothing reaches the SRAM while
   // rst is high, even though rr_ptr only clears at the edge.
   assign issue  = win_any & ~m_busy & ~rst;
   assign rsp_on = rd_pend & ~rst;

   always_comb begin
      req_gnt = '0;
      rsp_vld = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_gnt[i] = issue && (winner == PW'(i));
         rsp_vld[i] = rsp_on && (owner == PW'(i));
      end
   end

   // Address and write data follow the winner even when idle; only the
   // qualifying strobes are forced low.
   assign m_cs      = issue;
   assign m_we      = issue & win_we;
   assign m_byte    = issue ? win_byte : '0;
   assign m_addr    = win_addr;
   assign m_di      = win_wdata;
   assign rsp_rdata = rsp_on ? m_do : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr  <= '0;
         owner   <= '0;
         rd_pend <= 1'b0;
      end else begin
         rd_pend <= issue & ~win_we;
         if (issue) begin
            rr_ptr <= (winner == PW'(NREQ-1)) ? '0 : winner + PW'(1);
            if (!win_we)
               owner <= winner;
         end
      end
   end

`ifdef SRAM_PORT_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_gnt_cnt   <= '0;
         perf_stall_cnt <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_gnt[i] && (perf_gnt_cnt[i*32 +: 32] != 32'hFFFF_FFFF))
               perf_gnt_cnt[i*32 +: 32] <= perf_gnt_cnt[i*32 +: 32] + 32'd1;
         end
         if (win_any && !issue && (perf_stall_cnt != 32'hFFFF_FFFF))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sram_port_arb.sv
// tb/tb_sram_port_arb.sv - scoreboard testbench for sram_port_arb
module tb_sram_port_arb;

   localparam int NREQ = 4;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int BW   = DW / 8;

   logic                 clk;
   logic                 rst;
   logic [NREQ-1:0]      req_vld;
   logic [NREQ-1:0]      req_we;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*BW-1:0]   req_byte;
   logic [NREQ*DW-1:0]   req_wdata;
   logic [NREQ-1:0]      req_gnt;
   logic [NREQ-1:0]      rsp_vld;
   logic [DW-1:0]        rsp_rdata;
   logic                 m_cs;
   logic                 m_we;
   logic [AW-1:0]        m_addr;
   logic [BW-1:0]        m_byte;
   logic [DW-1:0]        m_di;
   logic [DW-1:0]        m_do;
   logic                 m_busy;
`ifdef SRAM_PORT_ARB_PERF_EN
   logic [NREQ*32-1:0]   perf_gnt_cnt;
   logic [31:0]          perf_stall_cnt;
`endif

   sram_port_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_vld   (req_vld),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_byte  (req_byte),
      .req_wdata (req_wdata),
      .req_gnt   (req_gnt),
      .rsp_vld   (rsp_vld),
      .rsp_rdata (rsp_rdata),
      .m_cs      (m_cs),
      .m_we      (m_we),
      .m_addr    (m_addr),
      .m_byte    (m_byte),
      .m_di      (m_di),
      .m_do      (m_do),
      .m_busy    (m_busy)
`ifdef SRAM_PORT_ARB_PERF_EN
      ,
      .perf_gnt_cnt   (perf_gnt_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   typedef struct {
      int          cyc;
      logic [3:0]  gnt;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  byt;
      logic [31:0] di;
   } gnt_t;

   typedef struct {
      int          cyc;
      logic [3:0]  vld;
      logic [31:0] data;
   } rsp_t;

   gnt_t gq[$];
   rsp_t rq[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic        r_we   [NREQ];
   logic [31:0] r_addr [NREQ];
   logic [3:0]  r_byte [NREQ];
   logic [31:0] r_wdata[NREQ];
   logic [31:0] mem    [256];

   always_comb begin
      req_we    = '0;
      req_addr  = '0;
      req_byte  = '0;
      req_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_we[i]              = r_we[i];
         req_addr[i*AW +: AW]   = r_addr[i];
         req_byte[i*BW +: BW]   = r_byte[i];
         req_wdata[i*DW +: DW]  = r_wdata[i];
      end
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // SRAM model: 1-cycle read latency, byte-masked writes.
   initial begin
      m_do = '0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h40] = 32'hDEADBEEF;
      for (int i = 0; i < 4; i++) mem[8'h80 + i] = 32'hA000_0000 + i;
      forever begin
         @(posedge clk);
         if (m_cs && !m_we)
            m_do <= mem[m_addr[9:2]];
         if (m_cs && m_we)
            for (int b = 0; b < 4; b++)
               if (m_byte[b]) mem[m_addr[9:2]][b*8 +: 8] = m_di[b*8 +: 8];
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a grant or a
   // response, and checks idle strobes otherwise.
   initial forever begin
      gnt_t g;
      rsp_t r;
      @(negedge clk);
      checks = checks + 1;
      if (m_cs) begin
         if (gq.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_grant cyc=%0d gnt=%b addr=%h required no grant", cyc, req_gnt, m_addr);
         end else begin
            g = gq.pop_front();
            if (g.cyc != cyc || req_gnt !== g.gnt || m_we !== g.we || m_addr !== g.addr ||
                m_byte !== g.byt || m_di !== g.di) begin
               errors = errors + 1;
               $display("FAIL grant cyc=%0d gnt=%b we=%b addr=%h byte=%h di=%h required cyc=%0d gnt=%b we=%b addr=%h byte=%h di=%h",
                        cyc, req_gnt, m_we, m_addr, m_byte, m_di, g.cyc, g.gnt, g.we, g.addr, g.byt, g.di);
            end
         end
      end else if (req_gnt !== 4'b0 || m_we !== 1'b0 || m_byte !== 4'h0 ||
                   (gq.size() > 0 && gq[0].cyc <= cyc)) begin
         errors = errors + 1;
         $display("FAIL idle cyc=%0d gnt=%b we=%b byte=%h pending_grants=%0d required gnt=0000 we=0 byte=0 and no grant due",
                  cyc, req_gnt, m_we, m_byte, gq.size());
      end
      checks = checks + 1;
      if (rsp_vld !== 4'b0) begin
         if (rq.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_rsp cyc=%0d rsp_vld=%b rdata=%h required no response", cyc, rsp_vld, rsp_rdata);
         end else begin
            r = rq.pop_front();
            if (r.cyc != cyc || rsp_vld !== r.vld || rsp_rdata !== r.data) begin
               errors = errors + 1;
               $display("FAIL rsp cyc=%0d rsp_vld=%b rdata=%h required cyc=%0d rsp_vld=%b rdata=%h",
                        cyc, rsp_vld, rsp_rdata, r.cyc, r.vld, r.data);
            end
         end
      end else if (rsp_rdata !== 32'h0 || (rq.size() > 0 && rq[0].cyc <= cyc)) begin
         errors = errors + 1;
         $display("FAIL rsp_idle cyc=%0d rdata=%h pending_rsps=%0d required rdata=0 and no response due",
                  cyc, rsp_rdata, rq.size());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic we, input logic [31:0] addr,
                          input logic [3:0] byt, input logic [31:0] wd);
      r_we[i]    = we;
      r_addr[i]  = addr;
      r_byte[i]  = byt;
      r_wdata[i] = wd;
   endtask

   task automatic exp_g(input logic [3:0] gnt, input int i);
      gnt_t g;
      g.cyc  = cyc;
      g.gnt  = gnt;
      g.we   = r_we[i];
      g.addr = r_addr[i];
      g.byt  = r_byte[i];
      g.di   = r_wdata[i];
      gq.push_back(g);
   endtask

   task automatic exp_r(input logic [3:0] vld, input logic [31:0] data);
      rsp_t r;
      r.cyc  = cyc + 1;
      r.vld  = vld;
      r.data = data;
      rq.push_back(r);
   endtask

   initial begin
      rst     = 1'b1;
      m_busy  = 1'b0;
      req_vld = 4'b0;
      for (int i = 0; i < NREQ; i++)
         set_req(i, 1'b0, 32'h200 + 32'(i * 4), 4'hF, 32'h5555_0000 + 32'(i));
      tick();

      // Reset with every requester asserting: nothing may be issued.
      req_vld = 4'b1111;
      tick();
      tick();

      // Single read from requester 1.
      rst     = 1'b0;
      req_vld = 4'b0010;
      set_req(1, 1'b0, 32'h100, 4'hF, 32'h5555_0001);
      exp_g(4'b0010, 1);
      exp_r(4'b0010, 32'hDEADBEEF);
      tick();
      req_vld = 4'b0;
      tick();

      // Fairness from reset: all four reading continuously.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_req(1, 1'b0, 32'h204, 4'hF, 32'h5555_0001);
      req_vld = 4'b1111;
      for (int j = 0; j < 8; j++) begin
         exp_g(4'b0001 << (j % 4), j % 4);
         exp_r(4'b0001 << (j % 4), 32'hA000_0000 + 32'(j % 4));
         tick();
      end
      req_vld = 4'b0;

      // Write then read of the same word; only bytes 3:2 are written.
      set_req(0, 1'b1, 32'h40, 4'hC, 32'h1234_5678);
      req_vld = 4'b0001;
      exp_g(4'b0001, 0);
      tick();
      set_req(1, 1'b0, 32'h40, 4'hF, 32'h5555_0001);
      req_vld = 4'b0010;
      exp_g(4'b0010, 1);
      exp_r(4'b0010, 32'h1234_0000);
      tick();

      // Busy stall with req2/req3 pending; rr_ptr stays at 2.
      set_req(2, 1'b1, 32'h80, 4'hF, 32'h2222_2222);
      set_req(3, 1'b1, 32'h84, 4'hF, 32'h3333_3333);
      req_vld = 4'b1100;
      m_busy  = 1'b1;
      tick();
      tick();
      tick();
      m_busy = 1'b0;
      exp_g(4'b0100, 2);
      tick();
      req_vld = 4'b1000;
      exp_g(4'b1000, 3);
      tick();
      req_vld = 4'b0;
`ifdef SRAM_PORT_ARB_PERF_EN
      checks = checks + 1;
      if (perf_stall_cnt !== 32'd3) begin
         errors = errors + 1;
         $display("FAIL perf_stall got=%0d required=3", perf_stall_cnt);
      end
`endif

      // Read return is unaffected by busy in the following cycle.
      set_req(0, 1'b0, 32'h200, 4'hF, 32'h5555_0000);
      set_req(3, 1'b0, 32'h20C, 4'hF, 32'h5555_0003);
      req_vld = 4'b0001;
      exp_g(4'b0001, 0);
      exp_r(4'b0001, 32'hA000_0000);
      tick();
      req_vld = 4'b1000;
      m_busy  = 1'b1;
      tick();
      m_busy = 1'b0;
      exp_g(4'b1000, 3);
      exp_r(4'b1000, 32'hA000_0003);
      tick();
      req_vld = 4'b0;
      tick();

      // Reset the cycle after a read grant drops the response and rr_ptr.
      set_req(1, 1'b0, 32'h204, 4'hF, 32'h5555_0001);
      req_vld = 4'b0010;
      exp_g(4'b0010, 1);
      tick();
      rst     = 1'b1;
      req_vld = 4'b0;
      tick();
      rst = 1'b0;
`ifdef SRAM_PORT_ARB_PERF_EN
      checks = checks + 1;
      if (perf_gnt_cnt !== '0 || perf_stall_cnt !== 32'd0) begin
         errors = errors + 1;
         $display("FAIL perf_reset gnt_cnt=%h stall_cnt=%h required 0", perf_gnt_cnt, perf_stall_cnt);
      end
`endif
      req_vld = 4'b1010;
      exp_g(4'b0010, 1);
      exp_r(4'b0010, 32'hA000_0001);
      tick();
      req_vld = 4'b0;
      tick();
      tick();

      checks = checks + 1;
      if (gq.size() != 0 || rq.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain grants_left=%0d rsps_left=%0d required 0 0", gq.size(), rq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
